// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multicycle MIPS control unit.
// Contents: state encoding, opcode/funct constants, alucontrol and aluop
// encodings, and a helper that flags R-type funct values the ALU supports.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ORIEX   = 4'd10,
      S_IMMWB   = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] AOP_ADD   = 2'b00;
   localparam logic [1:0] AOP_SUB   = 2'b01;
   localparam logic [1:0] AOP_FUNCT = 2'b10;
   localparam logic [1:0] AOP_OR    = 2'b11;

   function automatic logic funct_legal(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
             (f == FN_OR)  || (f == FN_SLT);
   endfunction

endpackage

// File: rtl/mips_aludec.sv
// mips_aludec: combinational ALU decoder.
// Ports: aluop[1:0] (00 add, 01 sub, 10 use funct, 11 or), funct[5:0],
//        alucontrol[2:0] out. Unknown funct values fall back to add.
module mips_aludec
   import mips_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         AOP_ADD: alucontrol = ALU_ADD;
         AOP_SUB: alucontrol = ALU_SUB;
         AOP_OR:  alucontrol = ALU_OR;
         default: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM.
// Inputs : clk, reset (sync, active-high), op/funct from the instruction
//          register, zero from the ALU, mem_ready from memory.
// Outputs: memory strobes (mem_req, memwrite, iord), datapath enables
//          (irwrite, pcen, regwrite), mux selects (regdst, memtoreg,
//          alusrca, alusrcb, extzero, pcsrc), alucontrol, illegal_op pulse,
//          and the current state for debug.
// Handshake: a memory state (FETCH, MEMRD, MEMWR) completes in a cycle where
// mem_ready=1 (or always when HANDSHAKE=0); until then it holds with all
// outputs stable. mem_ready is ignored in every other state.
module mips_mc_controller
   import mips_pkg::*;
#(
   parameter int HANDSHAKE  = 1,
   parameter int ENABLE_BNE = 1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       iord,
   output logic       irwrite,
   output logic       pcen,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       extzero,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal_op,
   output logic [3:0] state
);

   state_t     state_q, state_d;
   logic [5:0] op_q;
   logic [1:0] aluop;
   logic       alu_used;
   logic [2:0] aludec_out;
   logic       mem_done;

   assign mem_done = (HANDSHAKE == 0) ? 1'b1 : mem_ready;
   assign state    = state_q;

   mips_aludec u_aludec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (aludec_out)
   );

   // Outside ALU-using states alucontrol reads as 000.
   assign alucontrol = alu_used ? aludec_out : 3'b000;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= 6'd0;
      end else begin
         state_q <= state_d;
         // Captured on leaving DECODE so later IR changes cannot steer
         // the instruction already in flight.
         if (state_q == S_DECODE) op_q <= op;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      extzero    = 1'b0;
      pcsrc      = 2'b00;
      aluop      = AOP_ADD;
      alu_used   = 1'b0;
      illegal_op = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            alusrcb  = 2'b01;
            alu_used = 1'b1;
            irwrite  = mem_done;
            pcen     = mem_done;
            if (mem_done) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb  = 2'b11;
            alu_used = 1'b1;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_BNE: begin
                  if (ENABLE_BNE != 0) begin
                     state_d = S_BRANCH;
                  end else begin
                     illegal_op = 1'b1;
                     state_d    = S_FETCH;
                  end
               end
               OP_ADDI:      state_d = S_ADDIEX;
               OP_ORI:       state_d = S_ORIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            alu_used = 1'b1;
            state_d  = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_done) state_d = S_MEMWB;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
            if (mem_done) state_d = S_FETCH;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            state_d  = S_FETCH;
         end
         S_EXECUTE: begin
            alusrca    = 1'b1;
            aluop      = AOP_FUNCT;
            alu_used   = 1'b1;
            illegal_op = ~funct_legal(funct);
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            alu_used = 1'b1;
            state_d  = S_IMMWB;
         end
         S_ORIEX: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            extzero  = 1'b1;
            aluop    = AOP_OR;
            alu_used = 1'b1;
            state_d  = S_IMMWB;
         end
         S_IMMWB: begin
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            alusrca  = 1'b1;
            aluop    = AOP_SUB;
            alu_used = 1'b1;
            pcsrc    = 2'b01;
            pcen     = ((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero);
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pcsrc   = 2'b10;
            pcen    = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Reset suppresses every side effect, including mid-wait states.
      if (reset) begin
         pcen       = 1'b0;
         irwrite    = 1'b0;
         regwrite   = 1'b0;
         memwrite   = 1'b0;
         mem_req    = 1'b0;
         illegal_op = 1'b0;
      end
   end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational decoder with a state machine that sequences one shared memory port, the register file, and the ALU across several cycles. A parameterised memory handshake lets instruction/data memory take variable latency. It adds `bne`, `addi` and `ori` to the `lw`/`sw`/R-type/`beq`/`j` set. It sits between the instruction register and the datapath muxes/enables in `mips`.

## Interface
Parameters:
- `HANDSHAKE`, default 1: 1 = memory states wait for `mem_ready`; 0 = memory assumed single-cycle and `mem_ready` is ignored.
- `ENABLE_BNE`, default 1: 0 = opcode 000101 is treated as illegal.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instruction register [31:26].
- `funct` in 6: instruction register [5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access active.
- `memwrite` out 1: write strobe.
- `iord` out 1: address select; 0 = PC, 1 = ALUOut.
- `irwrite` out 1: load the instruction register.
- `pcen` out 1: PC load.
- `regwrite` out 1: register file write enable.
- `regdst` out 1: 1 = rd, 0 = rt.
- `memtoreg` out 1: 1 = data register, 0 = ALUOut.
- `alusrca` out 1: 0 = PC, 1 = A.
- `alusrcb` out 2: 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm shifted left 2.
- `extzero` out 1: zero-extend imm (for `ori`).
- `pcsrc` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal_op` out 1: one-cycle pulse in DECODE on an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
State machine states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ORIEX, IMMWB, JUMP.

Transitions:
- FETCH → DECODE once the memory access completes (see below).
- DECODE dispatches on `op`:
  - 100011 (`lw`) and 101011 (`sw`) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (`beq`) and 000101 (`bne`) → BRANCH.
  - 001000 (`addi`) → ADDIEX.
  - 001101 (`ori`) → ORIEX.
  - 000010 (`j`) → JUMP.
  - Any other opcode: pulse `illegal_op` and go to FETCH.
- MEMADR → MEMRD for `lw`, MEMWR for `sw`.
- MEMRD → MEMWB.
- EXECUTE → ALUWB.
- ADDIEX and ORIEX → IMMWB.
- MEMWB, MEMWR, ALUWB, IMMWB, BRANCH and JUMP → FETCH.

Outputs per state (any output not listed is 0):
- FETCH:
  - `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `pcsrc`=00, add.
  - `irwrite` and `pcen` are asserted only in the completing cycle.
- DECODE: `alusrca`=0, `alusrcb`=11, add (precomputes the branch target into ALUOut).
- MEMADR: `alusrca`=1, `alusrcb`=10, add.
- MEMRD: `mem_req`=1, `iord`=1.
- MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1 for every cycle spent in the state.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0.
- EXECUTE: `alusrca`=1, `alusrcb`=00; `alucontrol` from funct:
  - 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Other funct values → 010, with `illegal_op` pulsed in EXECUTE.
- ALUWB: `regwrite`=1, `regdst`=1, `memtoreg`=0.
- ADDIEX: `alusrca`=1, `alusrcb`=10, add.
- ORIEX: `alusrca`=1, `alusrcb`=10, `extzero`=1, or.
- IMMWB: `regwrite`=1, `regdst`=0, `memtoreg`=0.
- BRANCH:
  - `alusrca`=1, `alusrcb`=00, sub, `pcsrc`=01.
  - `pcen` = (`beq` & `zero`) | (`bne` & ~`zero`).
- JUMP: `pcsrc`=10, `pcen`=1.

Memory completion rule:
- FETCH, MEMRD and MEMWR complete in a cycle where `HANDSHAKE`=0 or `mem_ready`=1.
- Otherwise the state holds and all outputs stay stable.
- `mem_ready` outside memory states is ignored.

## Timing
- All outputs are Moore (decoded from `state` and the registered opcode), except `pcen` in BRANCH (depends on `zero`) and the FETCH strobes (gated by `mem_ready`).
- Cycles per instruction with zero wait states: `lw` 5, `sw`/R-type/`addi`/`ori` 4, `beq`/`bne`/`j` 3.
- Each memory wait cycle adds one cycle.
- Reset:
  - While `reset`=1, `pcen`, `irwrite`, `regwrite`, `memwrite`, `mem_req` and `illegal_op` are forced to 0.
  - The state becomes FETCH at the next edge.
  - Reset in any state (including mid-wait) aborts the instruction with no write.
  - First fetch request is in the cycle after `reset` deasserts.
- The opcode is latched on leaving DECODE; later `op` changes do not affect the instruction in flight.

## Structure
- Package `mips_pkg`: state encoding constants, opcode constants, funct constants, `alucontrol` constants.
- Sub-module `mips_aludec`: combinational mapping of (aluop[1:0], funct) → `alucontrol`, where aluop is 00 add, 01 sub, 10 funct, 11 or.
- The FSM resides in `mips_mc_controller`.

## Test plan
- `lw`, `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; `regwrite`=1 with `memtoreg`=1 in MEMWB only; `pcen`=1 once in FETCH.
- `sw`, `mem_ready` low for 3 cycles in MEMWR → `memwrite`=1 for 4 consecutive cycles, then FETCH; no `regwrite`.
- `beq` with `zero`=1 → `pcen`=1, `pcsrc`=01 in BRANCH. `bne` with `zero`=1 → `pcen`=0. `bne` with `ENABLE_BNE`=0 → `illegal_op` pulse.
- R-type with funct 101010 → `alucontrol`=111 in EXECUTE; `regdst`=1, `regwrite`=1 in ALUWB.
- `ori` → `extzero`=1, `alucontrol`=001 in ORIEX; `j` → `pcsrc`=10, `pcen`=1 in JUMP, 3 cycles total.
- Reset asserted during MEMRD wait → next state FETCH, `regwrite` never asserted. Opcode 111111 → `illegal_op` pulse in DECODE, then FETCH.
